// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes, sequencer states and the flag bundle.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] step;
  logic               last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign step = mplier_q[0] ? mcand_q : '0;
  assign last = (state_q == MUL) && (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MUL;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
        end
      end
      MUL: begin
        acc_d    = acc_q + step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) state_d = IDLE;
      end
    endcase
  end

  // done flags the final iteration; product already includes that iteration's partial
  // product so the parent can load it on the same edge the sequencer returns to IDLE.
  always_comb begin
    busy    = (state_q == MUL);
    done    = last;
    product = acc_q + step;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift, optional multi-cycle multiply,
// registered result and flags, tri-state bus driver.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             flags_in,
  input  logic             out,
  output logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  logic [WIDTH-1:0]   result_q, result_d;
  flags_t             flags_q, flags_d;
  logic               done_q;
  logic               mul_fi_q;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic               is_mul, load_alu, mul_go;
  op_e                op_sel;

  assign op_sel   = op_e'(op);
  assign is_mul   = MUL_EN && (op_sel == OP_MUL);
  assign load_alu = start && !mul_busy && !is_mul;
  assign mul_go   = start && is_mul;

  if (MUL_EN) begin : g_mul
    alu_seq_mul #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_go),
      .a      (a),
      .b      (b),
      .busy   (mul_busy),
      .done   (mul_done),
      .product(mul_prod)
    );
  end else begin : g_no_mul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      // Only reached without the multiplier: result and flags stay zero.
      OP_MUL: alu_res = '0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    if (mul_done) begin
      result_d = mul_prod[WIDTH-1:0];
      if (mul_fi_q) begin
        flags_d = {|mul_prod[2*WIDTH-1:WIDTH], ~|mul_prod[WIDTH-1:0], mul_prod[WIDTH-1], 1'b0};
      end
    end else if (load_alu) begin
      result_d = alu_res;
      if (flags_in) flags_d = {alu_c, ~|alu_res, alu_res[WIDTH-1], alu_v};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      mul_fi_q <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= mul_done | load_alu;
      if (mul_go && !mul_busy) mul_fi_q <= flags_in;
    end
  end

  assign bus      = out ? result_q : 'z;
  assign busy     = mul_busy;
  assign done     = done_q;
  assign carry    = flags_q.carry;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;
  assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table for single-cycle ops, scoreboard on done, hand sequences
// for multiply, busy-time starts, reset aborts and the multiplier-less build.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         start, start_nm, flags_in, out;
  wire  [W-1:0] bus, bus_nm;
  logic         busy, done, carry, zero, negative, overflow;
  logic         busy_nm, done_nm, carry_nm, zero_nm, negative_nm, overflow_nm;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start), .flags_in(flags_in),
    .out(out), .bus(bus), .busy(busy), .done(done), .carry(carry), .zero(zero),
    .negative(negative), .overflow(overflow)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nm (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start_nm), .flags_in(flags_in),
    .out(out), .bus(bus_nm), .busy(busy_nm), .done(done_nm), .carry(carry_nm),
    .zero(zero_nm), .negative(negative_nm), .overflow(overflow_nm)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fi;
    logic [W-1:0] res;
    logic [3:0]   cznv;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   cznv;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[13];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard: every done pops one expected record.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_with_busy", 32'(busy), 32'd0);
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("flags", 32'({carry, zero, negative, overflow}), 32'(e.cznv));
        if (out) check("result", 32'(bus), 32'(e.res));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic fi, input logic [W-1:0] res, input logic [3:0] cznv);
    exp_t e;
    op = o; a = xa; b = xb; flags_in = fi; start = 1'b1;
    e.res = res; e.cznv = cznv;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Called right after a multiply start; walks the WIDTH busy cycles.
  task automatic watch_busy(input logic [W-1:0] prev, input bit stray);
    for (int i = 0; i < int'(W); i++) begin
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_no_done", 32'(done), 32'd0);
      check("mul_bus_prev", 32'(bus), 32'(prev));
      start = 1'b0; a = 8'hAA; b = 8'h55; flags_in = 1'b1;
      if (stray && i == 2) begin op = OP_ADD; a = 8'h01; b = 8'h01; start = 1'b1; end
      if (stray && i == 4) begin op = OP_MUL; flags_in = 1'b0; start = 1'b1; end
      @(negedge clk);
    end
    start = 1'b0;
    check("mul_busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b1100};
    tbl[1]  = '{OP_ADD, 8'h10, 8'h20, 1'b0, 8'h30, 4'b1100};
    tbl[2]  = '{OP_SUB, 8'h05, 8'h07, 1'b1, 8'hFE, 4'b1010};
    tbl[3]  = '{OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011};
    tbl[4]  = '{OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000};
    tbl[5]  = '{OP_OR,  8'h0F, 8'hF0, 1'b1, 8'hFF, 4'b0010};
    tbl[6]  = '{OP_XOR, 8'hAA, 8'hAA, 1'b1, 8'h00, 4'b0100};
    tbl[7]  = '{OP_SHL, 8'h81, 8'h00, 1'b1, 8'h02, 4'b1000};
    tbl[8]  = '{OP_SHR, 8'h81, 8'h00, 1'b1, 8'h40, 4'b1000};
    tbl[9]  = '{OP_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0001};
    tbl[10] = '{OP_SUB, 8'h10, 8'h10, 1'b1, 8'h00, 4'b0100};
    tbl[11] = '{OP_SHR, 8'h01, 8'h00, 1'b1, 8'h00, 4'b1100};
    tbl[12] = '{OP_SHL, 8'h40, 8'h00, 1'b1, 8'h80, 4'b0010};

    rst = 1'b1; a = '0; b = '0; op = '0; start = 1'b0; start_nm = 1'b0;
    flags_in = 1'b0; out = 1'b1;
    repeat (2) @(negedge clk);
    check("rst0_bus", 32'(bus), 32'd0);
    check("rst0_flags", 32'({carry, zero, negative, overflow}), 32'd0);
    check("rst0_busy", 32'(busy), 32'd0);
    check("rst0_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Back-to-back single-cycle ops, one start per cycle.
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].fi, tbl[i].res, tbl[i].cznv);
    end
    wait_drain(4);
    check("bus_drive", 32'(bus), 32'h80);
    out = 1'b0;
    #1;
    check("bus_release", 32'(bus !== 8'h80), 32'd1);
    out = 1'b1;
    @(negedge clk);

    // Multiply with stray starts and operand changes while busy.
    issue(OP_MUL, 8'h0F, 8'h11, 1'b1, 8'hFF, 4'b0010);
    watch_busy(8'h80, 1'b1);
    wait_drain(3);
    issue(OP_MUL, 8'h10, 8'h10, 1'b1, 8'h00, 4'b1100);
    watch_busy(8'hFF, 1'b0);
    wait_drain(3);
    // flags_in=0 at start must hold flags even though flags_in rises while busy.
    issue(OP_MUL, 8'h03, 8'h05, 1'b0, 8'h0F, 4'b1100);
    watch_busy(8'h00, 1'b0);
    wait_drain(3);

    // Reset during the third multiply cycle aborts it with no done.
    op = OP_MUL; a = 8'h0F; b = 8'h11; flags_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bus", 32'(bus), 32'd0);
    check("abort_flags", 32'({carry, zero, negative, overflow}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_stay_idle", 32'(busy), 32'd0);
    end

    // Reset held two cycles in the middle of activity.
    issue(OP_SUB, 8'h05, 8'h07, 1'b1, 8'hFE, 4'b1010);
    wait_drain(3);
    op = OP_MUL; a = 8'h22; b = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_bus", 32'(bus), 32'd0);
    check("rst2_flags", 32'({carry, zero, negative, overflow}), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_done", 32'(done), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);

    // Build without the multiplier: MUL is a one-cycle op giving zero.
    op = OP_ADD; a = 8'h12; b = 8'h34; flags_in = 1'b1; start_nm = 1'b1;
    @(negedge clk);
    start_nm = 1'b0;
    check("nm_add_bus", 32'(bus_nm), 32'h46);
    op = OP_MUL; a = 8'h0F; b = 8'h11; flags_in = 1'b1; start_nm = 1'b1;
    @(negedge clk);
    start_nm = 1'b0;
    check("nm_mul_done", 32'(done_nm), 32'd1);
    check("nm_mul_busy", 32'(busy_nm), 32'd0);
    check("nm_mul_bus", 32'(bus_nm), 32'd0);
    check("nm_mul_flags", 32'({carry_nm, zero_nm, negative_nm, overflow_nm}), 32'b0100);
    @(negedge clk);
    check("nm_done_pulse", 32'(done_nm), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised successor to the CPU's 8-bit add/sub ALU. Executes an 8-operation set (add, sub, logic, shifts, multiply) and holds the result in a register. The result drives the shared tri-state bus when enabled. Carry/zero/negative/overflow flags are registered. Multiply is a multi-cycle shift-add sequence with a start/busy/done handshake; all other operations complete in one cycle. Sits between the A/B registers and the bus; flags feed the control unit for conditional jumps.

Parameters:
WIDTH, 8, datapath width in bits (A, B, bus, result); legal values are 4 to 32.
MUL_EN, 1, 1 instantiates the multiply sequencer; 0 makes OP_MUL a single-cycle op returning 0.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
a  input  WIDTH  operand A (from A register)
b  input  WIDTH  operand B (from B register)
op  input  3  operation select (encoding below)
start  input  1  begin operation; sampled at rising edge
flags_in  input  1  sampled with start; 1 = update flags when result loads
out  input  1  drive result onto bus
bus  output  WIDTH  result when out=1, else high-impedance
busy  output  1  multiply in progress
done  output  1  one-cycle pulse: result register just loaded
carry  output  1  carry/borrow flag
zero  output  1  result == 0
negative  output  1  result MSB
overflow  output  1  signed overflow

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high. On reset: result=0, carry=zero=negative=overflow=0, busy=0, done=0, FSM=IDLE. Reset mid-multiply aborts the operation; no done pulse is produced.
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD: C = bit WIDTH of a+b.
  - SUB: C = bit WIDTH of a-b (borrow, 1 when a<b unsigned).
  - V for ADD: operand signs equal and result sign differs.
  - V for SUB: operand signs differ and result sign differs from a.
  - AND/OR/XOR: C=0, V=0.
  - SHL: result=a<<1, C=a[WIDTH-1], V=0.
  - SHR: logical shift, result=a>>1, C=a[0], V=0.
  - MUL (unsigned): result = low WIDTH bits of a*b; C = 1 if the high WIDTH bits are nonzero; V=0.
  - Z and N are always derived from the loaded result.
- FSM states: IDLE, MUL.
- IDLE, start=1, op!=MUL (or MUL_EN=0):
  - Result loads at that same edge. done=1 for the following cycle.
  - Flags load at the same edge if flags_in=1; otherwise flags hold.
  - FSM stays in IDLE, so back-to-back starts every cycle are legal.
- IDLE, start=1, op=MUL, MUL_EN=1:
  - At that edge, a, b and flags_in are captured into internal registers, busy<=1, counter<=0, and the accumulator is cleared. FSM goes to MUL.
- MUL: one shift-add iteration per cycle, using a 2*WIDTH accumulator and a multiplicand shifted left each cycle.
  - After the WIDTH-th iteration edge (edge k+WIDTH for start at edge k): result/flags load, busy<=0, done<=1 for one cycle, FSM returns to IDLE.
  - Total latency is WIDTH cycles from start to result.
- start while busy=1 is ignored; captured operands are unaffected by changes on a/b.
- done is a single-cycle pulse and is never asserted together with busy.
- Result and flags hold between operations; flags also hold if flags_in was 0 at start.
- bus is combinational: out ? result : 'z. out is independent of busy, so driving during MUL shows the previous result.

Decomposition:
- Package alu_seq_pkg: op_e enum (OP_ADD..OP_MUL, 3-bit), state_e enum (IDLE, MUL), flag struct {carry, zero, negative, overflow}.
- Sub-module alu_seq_mul: the shift-add multiplier (start, a, b -> busy, done, 2*WIDTH product), instantiated under MUL_EN via generate. The top level holds the single-cycle datapath, result/flag registers and bus driver.

Test Plan:
1. Reset: hold rst 2 cycles mid-activity -> result=0, all flags 0, busy=0, done=0, bus='z with out=0.
2. ADD a=8'hFF, b=8'h01, flags_in=1 -> next cycle result=00, C=1, Z=1, N=0, V=0, done pulse; out=1 gives bus=00.
3. SUB a=8'h05, b=8'h07, flags_in=1 -> result=FE, C=1, N=1, Z=0. Then ADD 7F+01 -> 80, V=1, C=0.
4. Flags hold: ADD 10+20 with flags_in=0 after test 2 -> result=30, flags still C=1, Z=1.
5. MUL a=8'h0F, b=8'h11 -> busy for 8 cycles, result=FF, C=0. Then MUL 10*10 -> result=00, C=1, Z=1. A start issued during busy is ignored.
6. Reset asserted at cycle 3 of MUL -> busy=0, no done pulse, result=0. With MUL_EN=0, MUL gives 1-cycle done and result=0, Z=1.
